// File: rtl/hci_tcdm_loader_pkg.sv
// Shared types and helpers for the TCDM loader: FSM states, LFSR step, byte enables.
package hci_tcdm_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WDRAIN,
        S_READ,
        S_RDRAIN,
        S_DONE
    } loader_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [3:0]  BE_ALL    = 4'hF;

    // Galois LFSR, right shift: feedback taps applied when the shifted-out bit is 1
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/hci_lfsr32.sv
// 32-bit Galois LFSR with synchronous load; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module hci_lfsr32
    import hci_tcdm_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] seed_i,
    output logic [31:0] value_o
);

    // Load has priority over advance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_o <= 32'h1;
        end else if (load_i) begin
            value_o <= (seed_i == '0) ? 32'h1 : seed_i;
        end else if (en_i) begin
            value_o <= lfsr_next(value_o);
        end
    end

endmodule

// File: rtl/hci_tcdm_loader.sv
// Autonomous HCI initiator: fills a TCDM window with an LFSR word stream and
// optionally reads it back, counting mismatches against a second LFSR.
module hci_tcdm_loader
    import hci_tcdm_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  n_words_i,
    input  logic [31:0]           seed_i,
    input  logic                  verify_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0] tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [DATA_WIDTH-1:0] tcdm_data_o,
    output logic [3:0]            tcdm_be_o,
    input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
    input  logic                  tcdm_r_valid_i,
    output logic                  tcdm_r_ready_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    loader_state_e         state_q, state_d;
    logic                  req_q, req_d, wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] add_q, add_d, base_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, n_q, err_q;
    logic [31:0]           seed_q, issue_val, chk_val, issue_seed;
    logic                  verify_q;
    logic [OUT_W-1:0]      out_q, out_d;
    logic                  grant, rsp, room, latch;
    logic                  issue_load, issue_en, chk_en;

    assign grant = req_q & tcdm_gnt_i;
    assign rsp   = tcdm_r_valid_i & tcdm_r_ready_o;
    assign out_d = out_q + OUT_W'(grant) - OUT_W'(rsp);
    assign room  = out_d < OUT_W'(MAX_OUTSTANDING);

    assign busy_o         = (state_q == S_WRITE) || (state_q == S_WDRAIN) ||
                            (state_q == S_READ)  || (state_q == S_RDRAIN);
    assign tcdm_r_ready_o = busy_o;
    assign done_o         = (state_q == S_DONE);
    assign err_cnt_o      = err_q;
    assign tcdm_req_o     = req_q;
    assign tcdm_add_o     = add_q;
    assign tcdm_wen_o     = wen_q;
    assign tcdm_be_o      = BE_ALL;
    // Issue LFSR only advances on a granted write, so it already holds the presented word
    assign tcdm_data_o    = (state_q == S_WRITE) ? issue_val : '0;

    assign issue_seed = latch ? seed_i : seed_q;
    assign chk_en     = rsp && !clear_i && ((state_q == S_READ) || (state_q == S_RDRAIN));

    hci_lfsr32 i_issue_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (issue_load),
        .en_i    (issue_en),
        .seed_i  (issue_seed),
        .value_o (issue_val)
    );

    hci_lfsr32 i_check_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (latch),
        .en_i    (chk_en),
        .seed_i  (seed_i),
        .value_o (chk_val)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state and next registered request outputs
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wen_d      = wen_q;
        add_d      = add_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        issue_load = 1'b0;
        issue_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    latch      = 1'b1;
                    issue_load = 1'b1;
                    cnt_d      = '0;
                    add_d      = base_addr_i & ~ADDR_WIDTH'(3);
                    if (n_words_i == '0) begin
                        state_d = S_DONE;
                        req_d   = 1'b0;
                        wen_d   = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        req_d   = 1'b1;
                        wen_d   = 1'b0;
                    end
                end
            end
            S_WRITE, S_READ: begin
                issue_en = grant && (state_q == S_WRITE);
                if (grant && (cnt_q == n_q - CNT_WIDTH'(1))) begin
                    state_d = (state_q == S_WRITE) ? S_WDRAIN : S_RDRAIN;
                    req_d   = 1'b0;
                    wen_d   = 1'b1;
                end else begin
                    // An ungranted request always keeps room, since outstanding can only drop
                    req_d = room;
                    if (grant) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        add_d = add_q + ADDR_WIDTH'(4);
                    end
                end
            end
            S_WDRAIN: begin
                if (out_q == '0) begin
                    if (verify_q) begin
                        state_d    = S_READ;
                        issue_load = 1'b1;
                        cnt_d      = '0;
                        add_d      = base_q;
                        req_d      = 1'b1;
                        wen_d      = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RDRAIN: begin
                if (out_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_i) begin
            state_d    = S_IDLE;
            req_d      = 1'b0;
            wen_d      = 1'b1;
            add_d      = '0;
            cnt_d      = '0;
            latch      = 1'b0;
            issue_load = 1'b0;
            issue_en   = 1'b0;
        end
    end

    // Request outputs, counters and latched run configuration
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q    <= 1'b0;
            wen_q    <= 1'b1;
            add_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            base_q   <= '0;
            n_q      <= '0;
            seed_q   <= '0;
            verify_q <= 1'b0;
        end else begin
            req_q <= req_d;
            wen_q <= wen_d;
            add_q <= add_d;
            cnt_q <= cnt_d;
            out_q <= clear_i ? '0 : out_d;
            if (latch) begin
                base_q   <= base_addr_i & ~ADDR_WIDTH'(3);
                n_q      <= n_words_i;
                seed_q   <= seed_i;
                verify_q <= verify_i;
            end
        end
    end

    // Saturating readback mismatch counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else if (clear_i || latch) begin
            err_q <= '0;
        end else if (chk_en && (tcdm_r_data_i != chk_val) && (err_q != '1)) begin
            err_q <= err_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hci_tcdm_loader.sv
// Self-checking bench: TCDM memory model with configurable grant and response
// latency, scoreboard of expected requests, and directed run scenarios.
module tb_hci_tcdm_loader;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0, start_i = 1'b0, verify_i = 1'b0;
    logic [31:0] base_addr_i = '0, seed_i = '0;
    logic [15:0] n_words_i = '0;
    logic        busy_o, done_o;
    logic [15:0] err_cnt_o;
    logic        tcdm_req_o, tcdm_gnt_i = 1'b0, tcdm_wen_o, tcdm_r_valid_i = 1'b0, tcdm_r_ready_o;
    logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i = '0;
    logic [3:0]  tcdm_be_o;

    always #5 clk = ~clk;

    hci_tcdm_loader #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .n_words_i(n_words_i), .seed_i(seed_i),
        .verify_i(verify_i), .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_data_o(tcdm_data_o), .tcdm_be_o(tcdm_be_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .tcdm_r_ready_o(tcdm_r_ready_o)
    );

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        int          ep;
    } rsp_t;

    txn_t        exp_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] mem[logic [31:0]];
    int          total = 0, bad = 0;
    int          cyc = 0, gnt_wait = 0, rsp_delay = 1, wait_cnt = 0;
    int          rd_idx = 0, corrupt_idx = -1, outst = 0, max_out = 0, epoch = 0;
    bit          no_gnt = 1'b0, hold_valid = 1'b0;
    logic [65:0] hold_val;
    txn_t        m_e;
    rsp_t        m_r;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    // TCDM model: grants, responses and the request-side scoreboard, all at negedge
    always @(negedge clk) begin
        cyc++;
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            m_r = rsp_q.pop_front();
            tcdm_r_valid_i = 1'b1;
            tcdm_r_data_i  = m_r.data;
            if (m_r.ep == epoch && outst > 0) outst--;
        end
        if (hold_valid) begin
            if (!clear_i)
                check("hold", {tcdm_req_o, tcdm_wen_o, tcdm_add_o, tcdm_data_o}, hold_val);
            hold_valid = 1'b0;
        end
        tcdm_gnt_i = 1'b0;
        if (tcdm_req_o) begin
            if (no_gnt || wait_cnt < gnt_wait) begin
                if (!no_gnt) wait_cnt++;
                hold_valid = 1'b1;
                hold_val   = {1'b1, tcdm_wen_o, tcdm_add_o, tcdm_data_o};
            end else begin
                wait_cnt   = 0;
                tcdm_gnt_i = 1'b1;
                check("be", tcdm_be_o, 4'hF);
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    m_e = exp_q.pop_front();
                    check("txn", {tcdm_wen_o, tcdm_add_o, tcdm_data_o}, m_e);
                end
                if (!tcdm_wen_o) begin
                    mem[tcdm_add_o] = tcdm_data_o;
                    m_rd = 32'hBAD00000 ^ tcdm_add_o;
                end else begin
                    m_rd = mem.exists(tcdm_add_o) ? mem[tcdm_add_o] : 32'h0;
                    if (rd_idx == corrupt_idx) m_rd = 32'hDEADBEEF;
                    rd_idx++;
                end
                m_r.due  = cyc + rsp_delay;
                m_r.data = m_rd;
                m_r.ep   = epoch;
                rsp_q.push_back(m_r);
                outst++;
                if (outst > max_out) max_out = outst;
            end
        end
    end

    task automatic push_w(input logic wen, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.wen = wen; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic push_stream(input logic [31:0] base, input int n, input logic [31:0] seed, input bit vfy);
        logic [31:0] x, a;
        x = (seed == 0) ? 32'h1 : seed;
        a = base & ~32'h3;
        for (int i = 0; i < n; i++) begin
            push_w(1'b0, a, x);
            a = a + 32'd4;
            x = ref_step(x);
        end
        if (vfy) begin
            a = base & ~32'h3;
            for (int i = 0; i < n; i++) begin
                push_w(1'b1, a, 32'h0);
                a = a + 32'd4;
            end
        end
    endtask

    task automatic do_clear();
        int c;
        no_gnt = 1'b1;
        @(negedge clk); #1;
        clear_i = 1'b1;
        @(negedge clk); #1;
        clear_i = 1'b0;
        epoch++;
        outst = 0;
        exp_q.delete();
        check("clr_req", tcdm_req_o, 0);
        check("clr_busy", busy_o, 0);
        check("clr_done", done_o, 0);
        check("clr_err", err_cnt_o, 0);
        c = 0;
        while (rsp_q.size() != 0 && c < 100) begin @(negedge clk); #1; c++; end
        @(negedge clk); #1;
        check("late_err", err_cnt_o, 0);
        check("late_busy", busy_o, 0);
        check("late_req", tcdm_req_o, 0);
        check("late_done", done_o, 0);
        no_gnt = 1'b0;
    endtask

    task automatic run_case(input string name, input logic [31:0] base, input logic [15:0] n,
                            input logic [31:0] seed, input bit vfy, input logic [15:0] exp_err,
                            output int cycles);
        int c;
        rd_idx = 0;
        start_i = 1'b1; base_addr_i = base; n_words_i = n; seed_i = seed; verify_i = vfy;
        @(negedge clk); #1;
        start_i = 1'b0;
        if (n != 0) begin
            check({name, "_busy"}, busy_o, 1);
            check({name, "_req_rise"}, tcdm_req_o, 1);
        end
        c = 0;
        while (!done_o && c < 5000) begin @(negedge clk); #1; c++; end
        cycles = c;
        check({name, "_done"}, done_o, 1);
        check({name, "_busy_end"}, busy_o, 0);
        check({name, "_req_end"}, tcdm_req_o, 0);
        check({name, "_err"}, err_cnt_o, exp_err);
        check({name, "_sb_left"}, exp_q.size(), 0);
        check({name, "_rsp_left"}, rsp_q.size(), 0);
        if (!done_o) do_clear();
    endtask

    initial begin
        int c;
        logic [31:0] s;
        @(negedge clk); #1;
        check("rst_req", tcdm_req_o, 0);
        check("rst_wen", tcdm_wen_o, 1);
        check("rst_be", tcdm_be_o, 4'hF);
        check("rst_add", tcdm_add_o, 0);
        check("rst_data", tcdm_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_cnt_o, 0);
        check("rst_rready", tcdm_r_ready_o, 0);
        repeat (2) @(negedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk); #1;

        gnt_wait = 0; rsp_delay = 1;
        push_w(1'b0, 32'h100, 32'h00000001);
        push_w(1'b0, 32'h104, 32'h80200003);
        push_w(1'b0, 32'h108, 32'hC0300002);
        push_w(1'b0, 32'h10C, 32'h60180001);
        run_case("basic", 32'h100, 16'd4, 32'h1, 1'b0, 16'd0, c);

        push_stream(32'h100, 4, 32'h1, 1'b1);
        run_case("vpass", 32'h100, 16'd4, 32'h1, 1'b1, 16'd0, c);

        corrupt_idx = 2;
        push_stream(32'h100, 4, 32'h1, 1'b1);
        run_case("vfail", 32'h100, 16'd4, 32'h1, 1'b1, 16'd1, c);
        corrupt_idx = -1;

        gnt_wait = 3; rsp_delay = 6; max_out = 0;
        push_stream(32'h2000, 16, 32'h1234ABCD, 1'b1);
        run_case("bp", 32'h2000, 16'd16, 32'h1234ABCD, 1'b1, 16'd0, c);
        check("bp_maxout", max_out <= 4, 1);

        gnt_wait = 0; rsp_delay = 10; max_out = 0;
        push_stream(32'h3000, 12, 32'hCAFEF00D, 1'b0);
        run_case("sat", 32'h3000, 16'd12, 32'hCAFEF00D, 1'b0, 16'd0, c);
        check("sat_maxout", max_out, 4);

        rsp_delay = 1;
        push_w(1'b0, 32'h500, 32'h00000001);
        push_w(1'b0, 32'h504, 32'h80200003);
        run_case("seed0", 32'h500, 16'd2, 32'h0, 1'b0, 16'd0, c);

        push_w(1'b0, 32'hFFFFFFFC, 32'h00000001);
        push_w(1'b0, 32'h00000000, 32'h80200003);
        run_case("wrap", 32'hFFFFFFFC, 16'd2, 32'h1, 1'b0, 16'd0, c);

        gnt_wait = 1; rsp_delay = 2;
        s = $urandom;
        c = $urandom_range(5, 20);
        base_addr_i = {$urandom_range(0, 255), 2'b00} | 32'h8000 | 32'h3;
        push_stream(base_addr_i, c, s, 1'b1);
        run_case("rand", base_addr_i, 16'(c), s, 1'b1, 16'd0, c);

        // Clear mid-write with requests outstanding, then restart from IDLE
        gnt_wait = 0; rsp_delay = 8;
        push_stream(32'h4000, 16, 32'h600D5EED, 1'b0);
        start_i = 1'b1; base_addr_i = 32'h4000; n_words_i = 16; seed_i = 32'h600D5EED; verify_i = 1'b0;
        @(negedge clk); #1;
        start_i = 1'b0;
        c = 0;
        while (outst < 2 && c < 100) begin @(negedge clk); #1; c++; end
        check("clr_outst", outst >= 2, 1);
        check("clr_busy_pre", busy_o, 1);
        do_clear();

        rsp_delay = 1;
        run_case("n0", 32'h600, 16'd0, 32'h5, 1'b1, 16'd0, c);
        check("n0_latency", c, 0);

        gnt_wait = 1; rsp_delay = 3;
        push_stream(32'h7000, 6, 32'h0BADF00D, 1'b1);
        run_case("restart", 32'h7000, 16'd6, 32'h0BADF00D, 1'b1, 16'd0, c);
        check("max_out_all", max_out <= 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hci_tcdm_loader.md
Name: hci_tcdm_loader

Overview:
- Autonomous HCI initiator driving the external TCDM port of hci_system, upstream of that port.
- Fills a TCDM window with an LFSR-generated word stream, then optionally reads the window back and counts mismatches.
- Provides hardware bring-up and preload of TCDM before the datamovers run.

Parameters:
ADDR_WIDTH, 32, address width of the TCDM port
DATA_WIDTH, 32, data width; fixed at 32 (LFSR width)
CNT_WIDTH, 16, width of the word count and the error count
MAX_OUTSTANDING, 4, maximum granted requests awaiting r_valid (power of 2, >=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
start_i  in  1  single-cycle start pulse
base_addr_i  in  ADDR_WIDTH  window base; bits [1:0] ignored (forced 0)
n_words_i  in  CNT_WIDTH  number of words to write
seed_i  in  32  LFSR seed; 0 is replaced by 32'h1
verify_i  in  1  1 = run the readback phase after the write phase
busy_o  out  1  high from the cycle after start until DONE
done_o  out  1  level, high in DONE
err_cnt_o  out  CNT_WIDTH  readback mismatches, saturating
tcdm_req_o  out  1  HCI request
tcdm_gnt_i  in  1  HCI grant
tcdm_add_o  out  ADDR_WIDTH  byte address
tcdm_wen_o  out  1  0 = write, 1 = read (HCI polarity)
tcdm_data_o  out  32  write data
tcdm_be_o  out  4  byte enables, always 4'hF
tcdm_r_data_i  in  32  response data
tcdm_r_valid_i  in  1  response valid (also returned for writes)
tcdm_r_ready_o  out  1  response ready

Behaviour:
- Reset values: all outputs 0 except tcdm_wen_o = 1 and tcdm_be_o = 4'hF. FSM in IDLE, counters 0.
- FSM states: IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE.
- IDLE --start_i--> WRITE, or DONE if n_words_i == 0.
  - On start: latch base, n_words, verify and seed; clear err_cnt_o.
  - start_i is ignored outside IDLE and DONE.
- Issue side (WRITE, READ):
  - Outputs are registered. tcdm_req_o rises in the cycle after start.
  - Word i goes to address base + 4*i, wrapping modulo 2^ADDR_WIDTH.
  - req, add, wen and data stay stable until sampled with gnt=1.
  - Next word is presented in the cycle after the grant, giving 1 word/cycle under continuous gnt.
  - req is asserted only while outstanding < MAX_OUTSTANDING. A same-cycle r_valid handshake frees a slot in that same cycle.
- Issue LFSR (Galois, right shift): next = (x>>1) ^ (x[0] ? LFSR_POLY : 0), LFSR_POLY = 32'h80200003.
  - Word 0 data = seed.
  - The LFSR advances on each granted write.
- Outstanding counter:
  - +1 on req&gnt, -1 on r_valid&r_ready; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - Responses are in order. tcdm_r_ready_o = 1 in WRITE through RDRAIN.
- WRITE -> WDRAIN after the last write is granted.
- WDRAIN -> READ when outstanding == 0 and verify is set. Otherwise WDRAIN -> DONE.
  - Entering READ reloads the issue LFSR from the seed.
- Write-ack r_data is ignored.
- READ: tcdm_wen_o = 1, data_o = 0. READ -> RDRAIN after the last read is granted.
- Check side:
  - A separate check LFSR, loaded with the seed, advances once per read response.
  - If r_data != expected, err_cnt increments, saturating at all-ones.
- RDRAIN -> DONE when outstanding == 0.
- DONE: done_o = 1 and busy_o = 0. DONE --start_i--> behaves as from IDLE.
- Any r_valid in IDLE or DONE is ignored.
- clear_i has priority over everything, including start_i in the same cycle:
  - Next cycle: IDLE, req = 0, counters and err_cnt cleared.
  - An abandoned in-flight request is permitted; this is the global-clear exception to the HCI hold rule.
  - Late responses are ignored.

Decomposition:
- hci_tcdm_loader_pkg holds:
  - state enum loader_state_e
  - LFSR_POLY
  - function lfsr_next(logic [31:0])
  - BE_ALL = 4'hF
- One natural sub-module: hci_lfsr32 (load, enable, seed, value; zero-seed substitution). It is instantiated twice, for the issue and check streams.

Test Plan:
- Basic write, no verify: seed 1, base 32'h100, n 4, gnt held 1, r_valid 1 cycle after each gnt.
  - Required: writes to 0x100/0x104/0x108/0x10C with data 0x00000001, 0x80200003, 0xC0300002, 0x60180001; wen 0; done_o after the 4th ack; err_cnt 0.
- Verify pass: same run with verify 1 and a TCDM model echoing stored data.
  - Required: 4 reads with wen 1; err_cnt_o 0; done_o 1.
- Verify fail: corrupt the r_data of read 2 to 32'hDEADBEEF.
  - Required: err_cnt_o = 1.
- Backpressure: gnt low 3 cycles per request, r_valid delayed 6 cycles, n 16.
  - Required: req/add/data stable while gnt = 0; outstanding never > 4; all 16 writes complete in order.
- Boundaries:
  - n 0 -> done_o 1 cycle after start, no req.
  - seed 0 -> first data 32'h1.
  - base 32'hFFFFFFFC, n 2 -> addresses 0xFFFFFFFC, 0x00000000.
- Clear: clear_i mid-WRITE with 2 outstanding.
  - Required: req 0 next cycle, IDLE, late r_valid ignored; a new start runs cleanly.
